// File: rtl/wave_pkg.sv
// Shared game-state encodings and sizing helpers for the enemy wave engine
// and the state controller that drives it.
package wave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } game_state_e;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_DIGITS  = 4;

  // Smallest index width able to address n items; never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int k = 1; k < 31; k++) begin
      if ((1 << k) < n) begin
        r = k + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/enemy_wave_engine_if.sv
// Bundle between the game controller / pixel generator side and the wave engine.
interface enemy_wave_engine_if #(
  parameter int NUM_LANES = 8,
  parameter int V_W       = 10
);
  import wave_pkg::*;

  localparam int LANE_W = clog2(NUM_LANES);

  game_state_e                       game_state;
  logic                              tick;
  logic [LANE_W-1:0]                 rand_in;
  logic                              laser_fire;
  logic [LANE_W-1:0]                 laser_lane;
  logic [NUM_LANES-1:0]              enemy_active;
  logic [NUM_LANES*V_W-1:0]          enemy_v;
  logic                              hit_pulse;
  logic [LANE_W-1:0]                 hit_lane;
  logic                              breach;
  logic [2:0]                        level;
  logic [BCD_DIGITS*BCD_DIGIT_W-1:0] score_bcd;

  modport master (
    output game_state, tick, rand_in, laser_fire, laser_lane,
    input  enemy_active, enemy_v, hit_pulse, hit_lane, breach, level, score_bcd
  );

  modport slave (
    input  game_state, tick, rand_in, laser_fire, laser_lane,
    output enemy_active, enemy_v, hit_pulse, hit_lane, breach, level, score_bcd
  );

endinterface

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear, saturating at 9999.
module bcd_counter4
  import wave_pkg::*;
(
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clr_i,
  input  logic                              inc_i,
  output logic [BCD_DIGITS*BCD_DIGIT_W-1:0] bcd_o
);

  localparam int W = BCD_DIGITS * BCD_DIGIT_W;

  logic [W-1:0] bcd_q, bcd_d;
  logic         carry_s;

  // Ripple the +1 through the digits; an all-nines value is held.
  always_comb begin
    bcd_d   = bcd_q;
    carry_s = 1'b0;
    if (clr_i) begin
      bcd_d = '0;
    end else if (inc_i && (bcd_q != {BCD_DIGITS{4'd9}})) begin
      carry_s = 1'b1;
      for (int k = 0; k < BCD_DIGITS; k++) begin
        if (carry_s) begin
          if (bcd_q[k*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd9) begin
            bcd_d[k*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd0;
          end else begin
            bcd_d[k*BCD_DIGIT_W +: BCD_DIGIT_W] = bcd_q[k*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd1;
            carry_s = 1'b0;
          end
        end else begin
          bcd_d[k*BCD_DIGIT_W +: BCD_DIGIT_W] = bcd_q[k*BCD_DIGIT_W +: BCD_DIGIT_W];
        end
      end
    end else begin
      bcd_d = bcd_q;
    end
  end

  // Score register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bcd_q <= '0;
    end else begin
      bcd_q <= bcd_d;
    end
  end

  assign bcd_o = bcd_q;

endmodule

// File: rtl/enemy_wave_engine.sv
// Enemy lane manager: timed spawning, laser hit resolution, descent with breach
// detection, kill-driven level ramp and BCD scoring, all on one clock with a tick enable.
module enemy_wave_engine
  import wave_pkg::*;
#(
  parameter int NUM_LANES       = 8,
  parameter int V_W             = 10,
  parameter int V_LIMIT         = 420,
  parameter int BASE_STEP       = 2,
  parameter int SPAWN_TICKS     = 32,
  parameter int KILLS_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 7
) (
  input  logic                clk,
  input  logic                rst,
  enemy_wave_engine_if.slave  bus
);

  localparam int LANE_W = clog2(NUM_LANES);
  localparam int TMR_W  = clog2(SPAWN_TICKS);
  localparam int KC_W   = clog2(KILLS_PER_LEVEL + 1);

  logic [NUM_LANES-1:0]     active_q, active_d;
  logic [NUM_LANES*V_W-1:0] v_q, v_d;
  logic                     hit_pulse_q, hit_pulse_d;
  logic [LANE_W-1:0]        hit_lane_q, hit_lane_d;
  logic                     breach_q, breach_d;
  logic [2:0]               level_q, level_d;
  logic [KC_W-1:0]          kill_q, kill_d;
  logic [TMR_W-1:0]         timer_q, timer_d;

  logic                     hit_s;
  logic                     idle_s;
  logic                     play_s;
  logic [LANE_W-1:0]        cand0_s, cand1_s;
  logic [V_W:0]             step_s, v_next_s;

  // Decode the shot and the two spawn candidates; an out-of-range lane never hits.
  always_comb begin
    idle_s  = (bus.game_state == ST_IDLE);
    play_s  = (bus.game_state == ST_PLAY);
    if (bus.laser_fire && (int'(bus.laser_lane) < NUM_LANES)) begin
      hit_s = active_q[bus.laser_lane];
    end else begin
      hit_s = 1'b0;
    end
    cand0_s = LANE_W'(int'(bus.rand_in) % NUM_LANES);
    cand1_s = LANE_W'((int'(cand0_s) + 1) % NUM_LANES);
    step_s  = (V_W+1)'(BASE_STEP) + (V_W+1)'(level_q);
  end

  // Next-state: hit first, then descent, then spawn.
  always_comb begin
    active_d    = active_q;
    v_d         = v_q;
    hit_pulse_d = hit_pulse_q;
    hit_lane_d  = hit_lane_q;
    breach_d    = breach_q;
    level_d     = level_q;
    kill_d      = kill_q;
    timer_d     = timer_q;
    v_next_s    = '0;
    case (bus.game_state)
      ST_IDLE: begin
        active_d    = '0;
        v_d         = '0;
        hit_pulse_d = 1'b0;
        hit_lane_d  = '0;
        breach_d    = 1'b0;
        level_d     = '0;
        kill_d      = '0;
        timer_d     = '0;
      end
      ST_PLAY: begin
        hit_pulse_d = hit_s;
        if (hit_s) begin
          active_d[bus.laser_lane]                = 1'b0;
          v_d[int'(bus.laser_lane)*V_W +: V_W]    = '0;
          hit_lane_d                              = bus.laser_lane;
          if (kill_q == KC_W'(KILLS_PER_LEVEL - 1)) begin
            kill_d  = '0;
            level_d = (level_q < 3'(MAX_LEVEL)) ? level_q + 3'd1 : level_q;
          end else begin
            kill_d  = kill_q + KC_W'(1);
          end
        end else begin
          hit_lane_d = hit_lane_q;
        end
        if (bus.tick) begin
          for (int i = 0; i < NUM_LANES; i++) begin
            if (active_q[i] && !(hit_s && (int'(bus.laser_lane) == i))) begin
              v_next_s = {1'b0, v_q[i*V_W +: V_W]} + step_s;
              if (v_next_s >= (V_W+1)'(V_LIMIT)) begin
                active_d[i]        = 1'b0;
                v_d[i*V_W +: V_W]  = '0;
                breach_d           = 1'b1;
              end else begin
                v_d[i*V_W +: V_W]  = v_next_s[V_W-1:0];
              end
            end else begin
              v_next_s = v_next_s;
            end
          end
          // A lane being hit is still active this cycle, so it is never a spawn target.
          if (timer_q == TMR_W'(SPAWN_TICKS - 1)) begin
            timer_d = '0;
            if (!active_q[cand0_s]) begin
              active_d[cand0_s]                 = 1'b1;
              v_d[int'(cand0_s)*V_W +: V_W]     = '0;
            end else if (!active_q[cand1_s]) begin
              active_d[cand1_s]                 = 1'b1;
              v_d[int'(cand1_s)*V_W +: V_W]     = '0;
            end else begin
              timer_d = '0;
            end
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end else begin
          timer_d = timer_q;
        end
      end
      default: begin
        timer_d = timer_q;
      end
    endcase
  end

  // Engine state registers; all outputs come straight from here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q    <= '0;
      v_q         <= '0;
      hit_pulse_q <= 1'b0;
      hit_lane_q  <= '0;
      breach_q    <= 1'b0;
      level_q     <= '0;
      kill_q      <= '0;
      timer_q     <= '0;
    end else begin
      active_q    <= active_d;
      v_q         <= v_d;
      hit_pulse_q <= hit_pulse_d;
      hit_lane_q  <= hit_lane_d;
      breach_q    <= breach_d;
      level_q     <= level_d;
      kill_q      <= kill_d;
      timer_q     <= timer_d;
    end
  end

  bcd_counter4 u_score (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (idle_s),
    .inc_i  (play_s && hit_s),
    .bcd_o  (bus.score_bcd)
  );

  assign bus.enemy_active = active_q;
  assign bus.enemy_v      = v_q;
  assign bus.hit_pulse    = hit_pulse_q;
  assign bus.hit_lane     = hit_lane_q;
  assign bus.breach       = breach_q;
  assign bus.level        = level_q;

endmodule

// File: doc/enemy_wave_engine.md
Name: enemy_wave_engine

Overview:
- Parametrised successor to the fixed eight-enemy controller. Manages NUM_LANES descending enemies, one per lane.
- Handles timed random spawning, player-laser hit resolution, breach detection, level-based speed-up and a 4-digit BCD score.
- Sits between the game state controller and the pixel generator. Everything runs on one clock with a tick enable, replacing the divided-clock scheme.

Parameters:
- NUM_LANES, 8, number of enemy lanes/slots (2..16).
- V_W, 10, width of vertical position.
- V_LIMIT, 420, vertical position at or beyond which an enemy breaches.
- BASE_STEP, 2, pixels moved per tick at level 0.
- SPAWN_TICKS, 32, ticks between spawn attempts (>=2).
- KILLS_PER_LEVEL, 10, kills per level increment.
- MAX_LEVEL, 7, level saturation value.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- game_state  in  2  ST_IDLE / ST_PLAY / ST_OVER
- tick  in  1  single-cycle motion/spawn enable
- rand_in  in  LANE_W  random lane index, LANE_W = clog2(NUM_LANES)
- laser_fire  in  1  single-cycle laser shot strobe
- laser_lane  in  LANE_W  lane of the shot
- enemy_active  out  NUM_LANES  per-lane occupancy
- enemy_v  out  NUM_LANES*V_W  packed positions, lane i at [i*V_W +: V_W]
- hit_pulse  out  1  one-cycle strobe on a kill
- hit_lane  out  LANE_W  lane of the last kill
- breach  out  1  sticky flag: an enemy reached V_LIMIT
- level  out  3  current level
- score_bcd  out  16  four BCD digits, saturate at 9999

Behaviour:
- rst low (async): all outputs, positions, spawn timer, kill counter and level clear to 0.
- ST_IDLE (sync clear): same clear as reset, evaluated every cycle.
- ST_OVER: everything frozen; fire and tick ignored; outputs hold.
- ST_PLAY: normal operation. All outputs are registered, so effects appear the cycle after the cause.

Per-cycle priority in ST_PLAY: hit, then move, then spawn.

Hit:
- Condition: laser_fire=1 and lane laser_lane is active.
- Next cycle: enemy_active[lane]=0, v=0, hit_pulse=1, hit_lane=lane, score+1 (BCD, saturates at 9999), kill counter+1.
- laser_fire on an inactive lane, or a laser_lane index >= NUM_LANES: no effect.

Move:
- On tick, every active lane not hit this cycle computes v_next = v + step, with step = BASE_STEP + level.
- Compute in V_W+1 bits; no wrap-around.
- If v_next >= V_LIMIT: lane deactivates, v=0, breach=1 (sticky until ST_IDLE).
- If hit and move coincide in the same cycle, the hit wins: no breach, score increments.

Spawn:
- On tick, the spawn timer increments. At SPAWN_TICKS-1 it reloads to 0 and makes one spawn attempt.
- First choice is lane rand_in. If that lane is active, or is being hit this cycle, try (rand_in+1) mod NUM_LANES once.
- If both candidates are busy, the attempt is dropped.
- A spawned enemy has v=0 and active=1 on the next cycle.
- rand_in >= NUM_LANES is reduced mod NUM_LANES.

Level:
- When the kill counter reaches KILLS_PER_LEVEL-1 and a kill occurs, the counter resets to 0 and level increments (saturates at MAX_LEVEL).
- The new step applies from the next tick.

Decomposition:
- Shared package wave_pkg: game_state encodings ST_IDLE=2'd0, ST_PLAY=2'd1, ST_OVER=2'd2 (shared with state_controller); LANE_W function clog2; BCD digit width constant.
- One sub-module: bcd_counter4. It takes a synchronous clear and an increment, outputs 4 digits and saturates at 9999.

Test Plan:
- Reset and idle: rst low mid-play with 3 lanes active -> next sample: all outputs 0. With rst high in ST_IDLE and tick pulsing, no spawns occur.
- Spawn fallback: SPAWN_TICKS=4, rand_in=3 with lane 3 active -> after the 4th tick lane 4 becomes active with v=0. With lanes 3 and 4 both active, nothing spawns.
- Descent and breach: single enemy at level 0, V_LIMIT=420, BASE_STEP=2 -> v=418 after 209 ticks; the 210th tick sets breach=1 and enemy_active=0. breach holds until ST_IDLE.
- Hit vs breach same cycle: enemy at v=418 with laser_fire on its lane coincident with tick -> hit_pulse=1, score 0000->0001, breach stays 0.
- Level and score: 10 kills -> level=1, step=3, score_bcd=16'h0010. 70 kills -> level=7; further kills keep level at 7. Preload score 9999, then a kill -> score stays 16'h9999.
- Frozen state: ST_OVER with laser_fire and tick active -> positions, score and flags unchanged for 100 cycles.
